// File: rtl/dpwm_softstart_ctrl.sv
// DPWM configuration sequencer: clamped on-time commands, period-aligned updates,
// slew-limited soft-start, synchronous stop and hold-timed latched fault shutdown.
module dpwm_softstart_ctrl #(
  parameter int unsigned TON_W      = 11,
  parameter int unsigned DT_W       = 5,
  parameter int unsigned TON_MAX    = 900,
  parameter int unsigned STEP       = 4,
  parameter int unsigned DT1_VAL    = 5,
  parameter int unsigned DT2_VAL    = 5,
  parameter int unsigned FAULT_HOLD = 8
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_fault,
  input  logic             i_ts_last,
  input  logic [TON_W-1:0] i_ton_cmd,
  input  logic             i_ton_cmd_valid,
  output logic             o_ton_cmd_ready,
  output logic [TON_W-1:0] o_ton,
  output logic [DT_W-1:0]  o_dt1,
  output logic [DT_W-1:0]  o_dt2,
  output logic             o_enable,
  output logic [1:0]       o_state,
  output logic             o_fault_latched
);

  localparam int unsigned HOLD_W = $clog2(FAULT_HOLD + 1);
  localparam logic [TON_W-1:0]  TON_MAX_V = TON_W'(TON_MAX);
  localparam logic [TON_W:0]    STEP_V    = (TON_W + 1)'(STEP);
  localparam logic [HOLD_W-1:0] HOLD_V    = HOLD_W'(FAULT_HOLD);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t            state;
  logic [TON_W-1:0]  cmd_reg;
  logic              start_pend;
  logic              stop_arm;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TON_W:0]    ramp_sum;
  logic              cmd_take;

  // One extra bit so the ramp increment can never wrap past the target.
  assign ramp_sum = {1'b0, o_ton} + STEP_V;
  assign cmd_take = i_ton_cmd_valid & o_ton_cmd_ready;
  assign o_state  = state;
  assign o_dt1    = DT_W'(DT1_VAL);
  assign o_dt2    = DT_W'(DT2_VAL);

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state           <= ST_OFF;
      o_ton           <= '0;
      o_enable        <= 1'b0;
      o_fault_latched <= 1'b0;
      o_ton_cmd_ready <= 1'b1;
      cmd_reg         <= '0;
      start_pend      <= 1'b0;
      stop_arm        <= 1'b0;
      hold_cnt        <= '0;
    end else begin
      if (cmd_take) begin
        cmd_reg <= (i_ton_cmd > TON_MAX_V) ? TON_MAX_V : i_ton_cmd;
      end

      // Fault overrides everything and is not aligned to the period boundary.
      if (i_fault) begin
        state           <= ST_FAULT;
        o_ton           <= '0;
        o_enable        <= 1'b0;
        o_fault_latched <= 1'b1;
        o_ton_cmd_ready <= 1'b0;
        hold_cnt        <= '0;
        start_pend      <= 1'b0;
        stop_arm        <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            if (i_stop) begin
              start_pend <= 1'b0;
            end else if (i_ts_last && start_pend) begin
              state      <= ST_RAMP;
              o_enable   <= 1'b1;
              o_ton      <= '0;
              start_pend <= 1'b0;
              stop_arm   <= 1'b0;
            end else if (i_start) begin
              start_pend <= 1'b1;
            end
          end

          ST_RAMP, ST_RUN: begin
            if (i_ts_last && (stop_arm || i_stop)) begin
              state      <= ST_OFF;
              o_enable   <= 1'b0;
              o_ton      <= '0;
              stop_arm   <= 1'b0;
              start_pend <= 1'b0;
            end else begin
              if (i_stop) begin
                stop_arm <= 1'b1;
              end
              if (i_ts_last) begin
                if (state == ST_RUN) begin
                  o_ton <= cmd_reg;
                end else if (ramp_sum >= {1'b0, cmd_reg}) begin
                  o_ton <= cmd_reg;
                  state <= ST_RUN;
                end else begin
                  o_ton <= ramp_sum[TON_W-1:0];
                end
              end
            end
          end

          ST_FAULT: begin
            if (hold_cnt == HOLD_V) begin
              state           <= ST_OFF;
              o_fault_latched <= 1'b0;
              o_ton_cmd_ready <= 1'b1;
            end else if (i_ts_last) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end

          default: state <= ST_OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpwm_softstart_ctrl.sv
// Directed scoreboard bench for dpwm_softstart_ctrl: soft-start, clamp, stop,
// fault hold timing, simultaneous events and mid-ramp reset.
module tb_dpwm_softstart_ctrl;

  localparam int unsigned TON_W  = 11;
  localparam int unsigned DT_W   = 5;
  localparam int          STEP   = 4;
  localparam int          HOLD   = 8;
  localparam int          PERIOD = 50;
  localparam int S_OFF = 0, S_RAMP = 1, S_RUN = 2, S_FAULT = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             fault = 1'b0;
  logic             ts_last = 1'b0;
  logic [TON_W-1:0] ton_cmd = '0;
  logic             ton_cmd_valid = 1'b0;
  logic             ton_cmd_ready;
  logic [TON_W-1:0] ton;
  logic [DT_W-1:0]  dt1;
  logic [DT_W-1:0]  dt2;
  logic             enable;
  logic [1:0]       state;
  logic             fault_latched;

  dpwm_softstart_ctrl dut (
    .i_clk           (clk),
    .reset           (reset),
    .i_start         (start),
    .i_stop          (stop),
    .i_fault         (fault),
    .i_ts_last       (ts_last),
    .i_ton_cmd       (ton_cmd),
    .i_ton_cmd_valid (ton_cmd_valid),
    .o_ton_cmd_ready (ton_cmd_ready),
    .o_ton           (ton),
    .o_dt1           (dt1),
    .o_dt2           (dt2),
    .o_enable        (enable),
    .o_state         (state),
    .o_fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    ton;
    bit    en;
    int    st;
    bit    lat;
    bit    rdy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_ton  = 0;
  int   exp_st   = S_OFF;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic boundary();
    ts_last = 1'b1;
    tick();
    ts_last = 1'b0;
  endtask

  task automatic idle();
    tick(PERIOD - 1);
  endtask

  task automatic push(input string tag, input int t, input bit en, input int st,
                      input bit lat, input bit rdy);
    exp_t e;
    e.tag = tag; e.ton = t; e.en = en; e.st = st; e.lat = lat; e.rdy = rdy;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: got ton=%0d with no expectation queued", ton);
    end else begin
      e = sb.pop_front();
      assert (ton === TON_W'(e.ton) && enable === e.en && state === 2'(e.st) &&
              fault_latched === e.lat && ton_cmd_ready === e.rdy)
      else begin
        n_errors++;
        $error("FAIL %s: got ton=%0d en=%0b st=%0d lat=%0b rdy=%0b, want ton=%0d en=%0b st=%0d lat=%0b rdy=%0b",
               e.tag, ton, enable, state, fault_latched, ton_cmd_ready,
               e.ton, e.en, e.st, e.lat, e.rdy);
      end
    end
  endtask

  task automatic send_cmd(input int v);
    ton_cmd = TON_W'(v);
    ton_cmd_valid = 1'b1;
    tick();
    ton_cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One soft-start boundary toward target, expectation from the slew model.
  task automatic ramp_step(input int target);
    int nxt;
    nxt = exp_ton + STEP;
    if (nxt >= target) begin
      exp_ton = target;
      exp_st  = S_RUN;
    end else begin
      exp_ton = nxt;
    end
    push("ramp", exp_ton, 1'b1, exp_st, 1'b0, 1'b1);
    boundary();
    check();
    idle();
  endtask

  // HOLD boundaries in FAULT with i_fault low, then exit to OFF one clock later.
  task automatic fault_hold_exit(input string tag);
    for (int i = 1; i <= HOLD; i++) begin
      push({tag, "_hold"}, 0, 1'b0, S_FAULT, 1'b1, 1'b0);
      boundary();
      check();
      idle();
    end
    push({tag, "_exit"}, 0, 1'b0, S_OFF, 1'b0, 1'b1);
    tick();
    check();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    push("reset", 0, 1'b0, S_OFF, 1'b0, 1'b1);
    check();
    n_checks++;
    assert (dt1 === DT_W'(5) && dt2 === DT_W'(5))
    else begin
      n_errors++;
      $error("FAIL dead_times: got dt1=%0d dt2=%0d, want 5 5", dt1, dt2);
    end

    // Soft-start to 100
    send_cmd(100);
    pulse_start();
    push("start_pending", 0, 1'b0, S_OFF, 1'b0, 1'b1);
    check();
    tick(3);
    exp_ton = 0; exp_st = S_RAMP;
    push("ramp_entry", 0, 1'b1, S_RAMP, 1'b0, 1'b1);
    boundary();
    check();
    idle();
    for (int i = 0; i < 40 && exp_st == S_RAMP; i++) ramp_step(100);

    // Clamp and run update
    send_cmd(2000);
    push("clamp", 900, 1'b1, S_RUN, 1'b0, 1'b1);
    boundary(); check(); idle();
    send_cmd(300);
    push("run_update", 300, 1'b1, S_RUN, 1'b0, 1'b1);
    boundary(); check(); idle();

    // Capture coinciding with boundary: old value now, new value next
    ton_cmd = TON_W'(500); ton_cmd_valid = 1'b1; ts_last = 1'b1;
    push("simul_old", 300, 1'b1, S_RUN, 1'b0, 1'b1);
    tick();
    ton_cmd_valid = 1'b0; ts_last = 1'b0;
    check(); idle();
    push("simul_new", 500, 1'b1, S_RUN, 1'b0, 1'b1);
    boundary(); check(); idle();

    // Stop mid-period
    tick(10);
    stop = 1'b1;
    push("stop_armed", 500, 1'b1, S_RUN, 1'b0, 1'b1);
    tick();
    stop = 1'b0;
    check();
    tick(10);
    push("stop_wait", 500, 1'b1, S_RUN, 1'b0, 1'b1);
    check();
    tick(10);
    push("stop_done", 0, 1'b0, S_OFF, 1'b0, 1'b1);
    boundary(); check(); idle();

    // Fault mid-ramp at o_ton=40
    send_cmd(100);
    pulse_start();
    exp_ton = 0; exp_st = S_RAMP;
    push("ramp2_entry", 0, 1'b1, S_RAMP, 1'b0, 1'b1);
    boundary(); check(); idle();
    while (exp_ton < 40 && exp_st == S_RAMP) ramp_step(100);
    tick(5);
    fault = 1'b1;
    push("fault_entry", 0, 1'b0, S_FAULT, 1'b1, 1'b0);
    tick();
    fault = 1'b0;
    check();
    pulse_start();
    fault_hold_exit("fault_pulse");
    push("start_forgotten", 0, 1'b0, S_OFF, 1'b0, 1'b1);
    tick(5);
    boundary(); check(); idle();

    // Held fault for 20 periods
    fault = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      boundary();
      idle();
    end
    push("fault_held", 0, 1'b0, S_FAULT, 1'b1, 1'b0);
    check();
    tick(7);
    fault = 1'b0;
    tick();
    fault_hold_exit("fault_level");

    // Start and stop together in OFF: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(3);
    push("start_stop", 0, 1'b0, S_OFF, 1'b0, 1'b1);
    boundary(); check(); idle();

    // Reset mid-ramp returns everything, including cmd_reg, to reset values
    send_cmd(8);
    pulse_start();
    exp_ton = 0; exp_st = S_RAMP;
    push("ramp3_entry", 0, 1'b1, S_RAMP, 1'b0, 1'b1);
    boundary(); check(); idle();
    ramp_step(8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push("reset_midramp", 0, 1'b0, S_OFF, 1'b0, 1'b1);
    check();
    pulse_start();
    exp_ton = 0; exp_st = S_RAMP;
    push("ramp_zero_entry", 0, 1'b1, S_RAMP, 1'b0, 1'b1);
    boundary(); check(); idle();
    ramp_step(0);
    send_cmd(8);
    push("run_after_reset", 8, 1'b1, S_RUN, 1'b0, 1'b1);
    boundary(); check(); idle();

    // Fault coinciding with boundary: fault wins
    fault = 1'b1; ts_last = 1'b1;
    push("fault_vs_boundary", 0, 1'b0, S_FAULT, 1'b1, 1'b0);
    tick();
    fault = 1'b0; ts_last = 1'b0;
    check();

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpwm_softstart_ctrl.md
# dpwm_softstart_ctrl

Sequencer that drives the configuration inputs of the 200 kHz DPWM (ton, dt1, dt2, enable). It accepts on-time commands from the compensator over a valid/ready handshake. Commands are clamped to a safe maximum, and every duty change is aligned to the DPWM period-end strobe. The block also performs a slew-limited soft-start ramp, synchronous stop, and a latched, hold-timed fault shutdown.

## Interface
Parameters:
- TON_W, 11, width of on-time values (matches DPWM counter)
- DT_W, 5, width of dead-time values
- TON_MAX, 900, clamp applied to every accepted command; requires TON_MAX + DT1_VAL + DT2_VAL < 1000
- STEP, 4, on-time increment per switching period during soft-start (≥1)
- DT1_VAL, 5, constant driven on o_dt1
- DT2_VAL, 5, constant driven on o_dt2
- FAULT_HOLD, 8, minimum number of switching periods spent in FAULT (≥1)

Ports:
- i_clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- i_start  in  1  level/pulse request to start switching
- i_stop  in  1  level/pulse request to stop switching
- i_fault  in  1  protection fault, level
- i_ts_last  in  1  DPWM period-end strobe, one cycle per period
- i_ton_cmd  in  TON_W  requested on-time in clock counts
- i_ton_cmd_valid  in  1  command valid
- o_ton_cmd_ready  out  1  command accepted when valid & ready
- o_ton  out  TON_W  on-time to DPWM
- o_dt1  out  DT_W  leading dead time to DPWM
- o_dt2  out  DT_W  trailing dead time to DPWM
- o_enable  out  1  DPWM output enable
- o_state  out  2  OFF=0, RAMP=1, RUN=2, FAULT=3
- o_fault_latched  out  1  set on fault entry; cleared on FAULT→OFF

## Operation
- Reset values:
  - state OFF; o_ton=0; o_enable=0; o_fault_latched=0
  - cmd_reg=0; start_pend=0; hold counter 0
  - o_ton_cmd_ready=1; o_dt1/o_dt2 are constants
- Command capture:
  - Captured when i_ton_cmd_valid & o_ton_cmd_ready.
  - cmd_reg <= min(i_ton_cmd, TON_MAX).
  - o_ton_cmd_ready=0 only in FAULT.
- Priority per cycle: reset > i_fault > i_stop > i_start.
- OFF:
  - i_start (with i_fault=0) sets start_pend.
  - On i_ts_last with start_pend: go to RAMP, o_enable<=1, o_ton<=0, start_pend<=0.
- RAMP, on each i_ts_last:
  - sum = o_ton + STEP, computed in TON_W+1 bits, no wrap.
  - If sum ≥ cmd_reg: o_ton<=cmd_reg, go to RUN.
  - Else: o_ton<=sum.
  - If cmd_reg changes mid-ramp, the new value is the target. If cmd_reg ≤ current o_ton, the next boundary jumps to cmd_reg and enters RUN.
- RUN: on each i_ts_last, o_ton<=cmd_reg. No slew limit.
- Stop:
  - i_stop in RAMP or RUN arms a stop.
  - On the next i_ts_last: o_enable<=0, o_ton<=0, state OFF, start_pend cleared.
  - i_stop in OFF clears start_pend.
- Fault:
  - i_fault=1 in any state takes effect on the next clock, not boundary-aligned: o_enable<=0, o_ton<=0, state FAULT, o_fault_latched<=1, hold counter<=0.
  - While in FAULT, every i_ts_last increments the hold counter, saturating at FAULT_HOLD.
  - Exit to OFF when counter==FAULT_HOLD and i_fault==0; o_fault_latched<=0 on exit.
  - i_start during FAULT is ignored and not remembered.
  - A new i_fault in FAULT resets the hold counter to 0.
- o_ton and o_enable change only on the cycle after an i_ts_last, except on fault or reset.

## Timing
- All outputs are registered.
- Boundary update:
  - i_ts_last high in cycle N ⇒ new o_ton/o_enable visible in cycle N+1.
  - The DPWM loads ton at its next period end, so a duty change reaches the power stage one full switching period after the controller boundary.
- Fault-to-disable latency: 1 clock.
- Soft-start duration to target T: ceil(T/STEP) boundaries after the RAMP-entry boundary.
- Simultaneous events:
  - i_ts_last together with a command capture: the boundary uses the old cmd_reg; the new value applies at the following boundary.
  - i_start and i_stop together in OFF: stop wins, start_pend=0.
  - i_fault together with i_ts_last: fault wins.
- Reset asserted mid-ramp: all state returns to reset values on the next clock.

## Test plan
- Soft-start:
  - Stimulus: reset, cmd 100 accepted, i_start, i_ts_last every 1000 clocks.
  - Response: o_enable rises after the first boundary with o_ton=0; o_ton then reads 4, 8, …, 100 on successive boundaries; state goes RUN when o_ton=100.
- Clamp and run update:
  - Stimulus: in RUN, cmd 2000 accepted.
  - Response: o_ton=900 after the next boundary; cmd 300 gives o_ton=300 after the following boundary.
- Fault mid-ramp:
  - Stimulus: i_fault pulse at o_ton=40.
  - Response: o_enable=0, o_ton=0 one clock later; o_fault_latched=1; ready=0; state stays FAULT for 8 boundaries, then goes to OFF with latch cleared.
- Held fault:
  - Stimulus: i_fault held high for 20 periods.
  - Response: FAULT persists until i_fault falls; OFF is entered on the first cycle with counter==8 and i_fault=0.
- Stop:
  - Stimulus: i_stop mid-period in RUN.
  - Response: outputs unchanged until the next i_ts_last; the cycle after it gives o_enable=0, o_ton=0, state OFF.
- Simultaneous events:
  - Stimulus: command capture coinciding with i_ts_last.
  - Response: the old value is applied at that boundary; the new value at the next boundary.
